mono_cfg_loader: RTL and testbench

Parametrised configuration loader for the MONOPIX-class pixel matrix and its global register: one serial port addresses either the global register or a single column of pixels, with a framed header, length checking, atomic commit and readback of the previous contents. It replaces the single long pixel shift chain and the externally strobed load enables with an internal framing FSM. It sits between the configuration serial interface and the analogue front-end/DAC model.

---
 rtl/mono_cfg_pkg.sv | 36 +++
 rtl/mono_cfg_shadow.sv | 52 +++++
 rtl/mono_cfg_loader.sv | 184 ++++++++++++++++++
 tb/tb_mono_cfg_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mono_cfg_pkg.sv
// Shared constants, state/error encodings and size helpers for the
// MONOPIX configuration loader.
package mono_cfg_pkg;

    localparam int HDR_W       = 8;
    localparam int HDR_TGT     = 7;
    localparam int HDR_WR      = 6;
    localparam int HDR_ADDR_HI = 5;

    localparam logic [5:0] GLOBAL_ADDR = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_COMMIT,
        ST_SINK
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_ADDR = 2'b10
    } err_t;

    function automatic int npb(input int ntrim);
        return ntrim + 3;
    endfunction

    function automatic int lmax(input int glb_w, input int nrow, input int ntrim);
        int col_w;
        col_w = nrow * npb(ntrim);
        return (glb_w > col_w) ? glb_w : col_w;
    endfunction

endpackage

// File: rtl/mono_cfg_shadow.sv
// Shadow shift register: parallel load of committed contents, serial shift
// over the active length, and a bit counter saturating at len+1.
module mono_cfg_shadow #(
    parameter int LMAX = 903,
    parameter int CW   = 10
) (
    input  logic            SR_CLK,
    input  logic            SR_RST,
    input  logic            i_load,
    input  logic [LMAX-1:0] i_load_data,
    input  logic            i_shift,
    input  logic            i_sin,
    input  logic [CW-1:0]   i_len,
    output logic [LMAX-1:0] o_sh,
    output logic [CW-1:0]   o_cnt
);

    logic [LMAX-1:0] r_sh;
    logic [CW-1:0]   r_cnt;
    logic [LMAX-1:0] w_nxt;
    logic [CW-1:0]   w_last;

    assign w_last = i_len - CW'(1);

    // New bit enters at len-1; bits above the active window hold their zeros.
    for (genvar i = 0; i < LMAX; i++) begin : g_bit
        if (i == LMAX - 1) begin : g_top
            assign w_nxt[i] = (w_last == CW'(i)) ? i_sin : r_sh[i];
        end else begin : g_mid
            assign w_nxt[i] = (w_last == CW'(i)) ? i_sin :
                              (CW'(i) < w_last)  ? r_sh[i+1] : r_sh[i];
        end
    end

    always_ff @(posedge SR_CLK or posedge SR_RST) begin
        if (SR_RST) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_load_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sh <= w_nxt;
            if (r_cnt <= i_len)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_sh  = r_sh;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/mono_cfg_loader.sv
// Framed serial configuration loader: header decode, length check, atomic
// commit into the global register or one pixel column, readback of old data.
module mono_cfg_loader
    import mono_cfg_pkg::*;
#(
    parameter int NCOL  = 36,
    parameter int NROW  = 129,
    parameter int NTRIM = 4,
    parameter int GLB_W = 197
) (
    input  logic                            SR_CLK,
    input  logic                            SR_RST,
    input  logic                            SR_EN,
    input  logic                            SR_IN,
    output logic                            SR_OUT,
    output logic [GLB_W-1:0]                GLB_CFG,
    output logic [NCOL*NROW*(NTRIM+3)-1:0]  PIX_CFG,
    output logic                            CFG_LD,
    output logic [5:0]                      LD_COL,
    output logic                            BUSY,
    output logic [1:0]                      ERR_CODE
);

    localparam int NPB  = npb(NTRIM);
    localparam int COLW = NROW * NPB;
    localparam int LM   = lmax(GLB_W, NROW, NTRIM);
    localparam int CW   = $clog2(LM + 2);
    localparam int PIXW = NCOL * COLW;

    state_t          r_state, w_nxt;
    logic [6:0]      r_hdr;
    logic [2:0]      r_hcnt;
    logic            r_tgt_col, r_wr;
    logic [5:0]      r_addr;
    logic [GLB_W-1:0] r_glb;
    logic [PIXW-1:0] r_pix;
    logic            r_ld, r_busy;
    logic [5:0]      r_ld_col;
    err_t            r_err;

    logic            w_hdr_start, w_hdr_shift, w_hdr_done, w_shift, w_commit;
    logic            w_err_set, w_load, w_bad_addr;
    err_t            w_err_val;
    logic [7:0]      w_hdr_full;
    logic [5:0]      w_hdr_addr, w_sel;
    logic [CW-1:0]   w_len, w_cnt;
    logic [LM-1:0]   w_sh, w_load_data;

    assign w_hdr_full = {r_hdr, SR_IN};
    assign w_hdr_addr = w_hdr_full[HDR_ADDR_HI:0];
    assign w_bad_addr = w_hdr_full[HDR_TGT] && (int'(w_hdr_addr) >= NCOL);
    assign w_sel      = (int'(w_hdr_addr) < NCOL) ? w_hdr_addr : 6'd0;
    assign w_len      = r_tgt_col ? CW'(COLW) : CW'(GLB_W);
    assign w_load     = w_hdr_done && !w_bad_addr;

    always_comb begin
        w_load_data = '0;
        if (w_hdr_full[HDR_TGT])
            w_load_data[COLW-1:0] = r_pix[int'(w_sel)*COLW +: COLW];
        else
            w_load_data[GLB_W-1:0] = r_glb;
    end

    mono_cfg_shadow #(.LMAX(LM), .CW(CW)) u_shadow (
        .SR_CLK      (SR_CLK),
        .SR_RST      (SR_RST),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_shift     (w_shift),
        .i_sin       (SR_IN),
        .i_len       (w_len),
        .o_sh        (w_sh),
        .o_cnt       (w_cnt)
    );

    always_ff @(posedge SR_CLK or posedge SR_RST) begin
        if (SR_RST) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt       = r_state;
        w_hdr_start = 1'b0;
        w_hdr_shift = 1'b0;
        w_hdr_done  = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_err_set   = 1'b0;
        w_err_val   = ERR_NONE;
        case (r_state)
            ST_IDLE, ST_COMMIT: begin
                w_commit = (r_state == ST_COMMIT);
                if (SR_EN) begin
                    w_nxt       = ST_HDR;
                    w_hdr_start = 1'b1;
                end else begin
                    w_nxt = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!SR_EN) begin
                    w_err_set = 1'b1;
                    w_err_val = ERR_LEN;
                    w_nxt     = ST_IDLE;
                end else if (r_hcnt == 3'd7) begin
                    w_hdr_done = 1'b1;
                    if (w_bad_addr) begin
                        w_err_set = 1'b1;
                        w_err_val = ERR_ADDR;
                        w_nxt     = ST_SINK;
                    end else begin
                        w_nxt = ST_DATA;
                    end
                end else begin
                    w_hdr_shift = 1'b1;
                end
            end
            ST_DATA: begin
                if (SR_EN) begin
                    w_shift = 1'b1;
                end else if (!r_wr) begin
                    w_nxt = ST_IDLE;
                end else if (w_cnt == w_len) begin
                    w_nxt = ST_COMMIT;
                end else begin
                    w_err_set = 1'b1;
                    w_err_val = ERR_LEN;
                    w_nxt     = ST_IDLE;
                end
            end
            ST_SINK: if (!SR_EN) w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge SR_CLK or posedge SR_RST) begin
        if (SR_RST) begin
            r_hdr     <= '0;
            r_hcnt    <= '0;
            r_tgt_col <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_glb     <= '0;
            r_pix     <= '0;
            r_ld      <= 1'b0;
            r_ld_col  <= GLOBAL_ADDR;
            r_busy    <= 1'b0;
            r_err     <= ERR_NONE;
        end else begin
            r_ld   <= w_commit;
            r_busy <= (w_nxt != ST_IDLE);
            if (w_hdr_start) begin
                r_hdr  <= {6'd0, SR_IN};
                r_hcnt <= 3'd1;
            end else if (w_hdr_shift) begin
                r_hdr  <= {r_hdr[5:0], SR_IN};
                r_hcnt <= r_hcnt + 3'd1;
            end
            if (w_hdr_done) begin
                r_tgt_col <= w_hdr_full[HDR_TGT];
                r_wr      <= w_hdr_full[HDR_WR];
                r_addr    <= w_hdr_addr;
            end
            // The first error sticks until a frame lands successfully.
            if (w_commit) begin
                if (r_tgt_col) r_pix[int'(r_addr)*COLW +: COLW] <= w_sh[COLW-1:0];
                else           r_glb <= w_sh[GLB_W-1:0];
                r_ld_col <= r_tgt_col ? r_addr : GLOBAL_ADDR;
                r_err    <= ERR_NONE;
            end else if (w_err_set && r_err == ERR_NONE) begin
                r_err <= w_err_val;
            end
        end
    end

    assign SR_OUT   = (r_state == ST_DATA) & w_sh[0];
    assign GLB_CFG  = r_glb;
    assign PIX_CFG  = r_pix;
    assign CFG_LD   = r_ld;
    assign LD_COL   = r_ld_col;
    assign BUSY     = r_busy;
    assign ERR_CODE = r_err;

endmodule

// File: tb/tb_mono_cfg_loader.sv
// Scoreboard bench: frame driver feeds a behavioural model that queues
// expected commits and readback bits; a monitor checks them as they appear.
module tb_mono_cfg_loader;

    localparam int NCOL  = 36;
    localparam int NROW  = 129;
    localparam int NTRIM = 4;
    localparam int GLB_W = 197;
    localparam int NPB   = NTRIM + 3;
    localparam int COLW  = NROW * NPB;
    localparam int PIXW  = NCOL * COLW;

    logic SR_CLK = 1'b0;
    logic SR_RST, SR_EN, SR_IN;
    logic SR_OUT, CFG_LD, BUSY;
    logic [GLB_W-1:0] GLB_CFG;
    logic [PIXW-1:0]  PIX_CFG;
    logic [5:0]       LD_COL;
    logic [1:0]       ERR_CODE;

    mono_cfg_loader #(.NCOL(NCOL), .NROW(NROW), .NTRIM(NTRIM), .GLB_W(GLB_W)) dut (
        .SR_CLK(SR_CLK), .SR_RST(SR_RST), .SR_EN(SR_EN), .SR_IN(SR_IN),
        .SR_OUT(SR_OUT), .GLB_CFG(GLB_CFG), .PIX_CFG(PIX_CFG), .CFG_LD(CFG_LD),
        .LD_COL(LD_COL), .BUSY(BUSY), .ERR_CODE(ERR_CODE)
    );

    always #5 SR_CLK = ~SR_CLK;

    typedef struct packed {
        logic [5:0]      col;
        logic [COLW-1:0] val;
    } commit_t;

    int n_tests = 0;
    int n_fail  = 0;
    int ld_seen = 0;

    logic [GLB_W-1:0] m_glb;
    logic [COLW-1:0]  m_col [NCOL];
    logic [1:0]       m_err;
    commit_t          exp_q[$];
    bit               rb_q[$];
    bit               g_pl[$];
    bit               rb_phase = 1'b0;
    bit               mon_e;
    commit_t          mon_c;
    logic [COLW-1:0]  mon_act;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: readback bits while the driver is streaming payload, commits on CFG_LD.
    always @(negedge SR_CLK) begin
        if (rb_phase) begin
            if (rb_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL readback: got %0b expected nothing queued", SR_OUT);
            end else begin
                mon_e = rb_q.pop_front();
                chk("readback", 64'(SR_OUT), 64'(mon_e));
            end
        end
        if (CFG_LD === 1'b1) begin
            ld_seen++;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL cfg_ld: got pulse for col %0h expected none", LD_COL);
            end else begin
                mon_c = exp_q.pop_front();
                chk("ld_col", 64'(LD_COL), 64'(mon_c.col));
                chk("err_on_commit", 64'(ERR_CODE), 64'd0);
                mon_act = '0;
                if (mon_c.col == 6'h3F) mon_act[GLB_W-1:0] = GLB_CFG;
                else                    mon_act = PIX_CFG[int'(mon_c.col)*COLW +: COLW];
                n_tests++;
                if (mon_act !== mon_c.val) begin
                    n_fail++;
                    for (int i = 0; i < COLW; i++)
                        if (mon_act[i] !== mon_c.val[i]) begin
                            $display("FAIL commit_data col %0h bit %0d: got %0b expected %0b",
                                     mon_c.col, i, mon_act[i], mon_c.val[i]);
                            break;
                        end
                end
            end
        end
    end

    task automatic drive(input bit en, input bit din);
        @(posedge SR_CLK);
        #1;
        SR_EN = en;
        SR_IN = din;
    endtask

    task automatic model_reset();
        m_glb = '0;
        for (int c = 0; c < NCOL; c++) m_col[c] = '0;
        m_err = 2'b00;
        exp_q.delete();
        rb_q.delete();
    endtask

    task automatic check_cfg(input string name);
        int bad_col;
        bad_col = -1;
        n_tests++;
        for (int c = 0; c < NCOL; c++)
            if (bad_col < 0 && PIX_CFG[c*COLW +: COLW] !== m_col[c]) bad_col = c;
        if (GLB_CFG !== m_glb) begin
            n_fail++;
            $display("FAIL %s: global register got %h expected %h", name, GLB_CFG, m_glb);
        end else if (bad_col >= 0) begin
            n_fail++;
            $display("FAIL %s: column %0d got different contents than expected", name, bad_col);
        end
    endtask

    task automatic set_pl_zero(input int n);
        g_pl.delete();
        for (int j = 0; j < n; j++) g_pl.push_back(1'b0);
    endtask

    task automatic set_pl_rand(input int n);
        g_pl.delete();
        for (int j = 0; j < n; j++) g_pl.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic end_checks(input string name);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0);
        @(negedge SR_CLK);
        chk({name, "_err"}, 64'(ERR_CODE), 64'(m_err));
        chk({name, "_busy"}, 64'(BUSY), 64'd0);
        check_cfg({name, "_cfg"});
    endtask

    // One frame: header MSB first, then g_pl; abort_at >= 0 asserts reset mid-payload.
    task automatic frame(input logic [7:0] hdr, input bit b2b, input int abort_at, input string name);
        bit tgt, wr, bad;
        int L, n;
        logic [5:0] addr;
        logic [COLW-1:0] oldv, newv;
        commit_t c;
        tgt  = hdr[7];
        wr   = hdr[6];
        addr = hdr[5:0];
        bad  = tgt && (int'(addr) >= NCOL);
        L    = tgt ? COLW : GLB_W;
        n    = g_pl.size();
        oldv = '0;
        if (!tgt)      oldv[GLB_W-1:0] = m_glb;
        else if (!bad) oldv = m_col[addr];
        for (int i = 7; i >= 0; i--) drive(1'b1, hdr[i]);
        for (int j = 0; j < n; j++) begin
            if (j == abort_at) begin
                @(posedge SR_CLK);
                #1;
                rb_phase = 1'b0;
                SR_EN    = 1'b0;
                SR_RST   = 1'b1;
                #1;
                model_reset();
                check_cfg({name, "_rst_cfg"});
                chk({name, "_rst_busy"}, 64'(BUSY), 64'd0);
                chk({name, "_rst_ld"}, 64'(CFG_LD), 64'd0);
                chk({name, "_rst_ldcol"}, 64'(LD_COL), 64'h3F);
                chk({name, "_rst_sr_out"}, 64'(SR_OUT), 64'd0);
                repeat (2) @(posedge SR_CLK);
                #1;
                SR_RST = 1'b0;
                return;
            end
            rb_q.push_back(bad ? 1'b0 : (j < L ? oldv[j] : g_pl[j-L]));
            drive(1'b1, g_pl[j]);
            rb_phase = 1'b1;
        end
        @(negedge SR_CLK);
        chk({name, "_busy_in_frame"}, 64'(BUSY), 64'd1);
        if (bad) begin
            if (m_err == 2'b00) m_err = 2'b10;
        end else if (wr) begin
            if (n == L) begin
                newv = '0;
                for (int j = 0; j < L; j++) newv[j] = g_pl[j];
                c.col = tgt ? addr : 6'h3F;
                c.val = newv;
                exp_q.push_back(c);
                if (tgt) m_col[addr] = newv;
                else     m_glb = newv[GLB_W-1:0];
                m_err = 2'b00;
            end else if (m_err == 2'b00) begin
                m_err = 2'b01;
            end
        end
        drive(1'b0, 1'b0);
        rb_phase = 1'b0;
        if (!b2b) end_checks(name);
    endtask

    initial begin
        int ld0;
        logic [7:0] hdr;
        int L, sel;
        SR_RST = 1'b1;
        SR_EN  = 1'b0;
        SR_IN  = 1'b0;
        model_reset();
        repeat (3) @(posedge SR_CLK);
        @(negedge SR_CLK);
        chk("reset_sr_out", 64'(SR_OUT), 64'd0);
        chk("reset_cfg_ld", 64'(CFG_LD), 64'd0);
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_ld_col", 64'(LD_COL), 64'h3F);
        chk("reset_err", 64'(ERR_CODE), 64'd0);
        check_cfg("reset_cfg");
        #1;
        SR_RST = 1'b0;

        set_pl_zero(GLB_W);
        g_pl[0] = 1'b1;
        g_pl[GLB_W-1] = 1'b1;
        ld0 = ld_seen;
        frame(8'h40, 1'b0, -1, "glb_write");
        chk("glb_write_pulses", 64'(ld_seen - ld0), 64'd1);
        chk("glb_ld_col", 64'(LD_COL), 64'h3F);

        set_pl_zero(COLW);
        for (int b = 0; b < NPB; b++) g_pl[3*NPB + b] = 1'(7'b1001010 >> b);
        frame(8'hC5, 1'b0, -1, "col5_write");
        chk("pix_5_3", 64'(PIX_CFG[(5*NROW+3)*NPB +: NPB]), 64'b1001010);
        chk("col5_ld_col", 64'(LD_COL), 64'd5);

        ld0 = ld_seen;
        set_pl_zero(COLW);
        frame(8'h85, 1'b0, -1, "col5_read");
        chk("read_no_commit", 64'(ld_seen - ld0), 64'd0);

        set_pl_rand(COLW - 1);
        frame(8'hC2, 1'b0, -1, "len_short");
        set_pl_rand(COLW + 1);
        frame(8'hC2, 1'b0, -1, "len_long");
        set_pl_rand(GLB_W);
        frame(8'h40, 1'b0, -1, "err_clear");

        set_pl_rand(50);
        frame(8'hE4, 1'b0, -1, "bad_addr");

        // Header cut short after 4 bits.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        end_checks("short_hdr");

        set_pl_rand(COLW);
        frame(8'hC7, 1'b0, 400, "rst_mid");
        check_cfg("post_rst_cfg");

        ld0 = ld_seen;
        set_pl_rand(COLW);
        frame(8'hC9, 1'b1, -1, "b2b_a");
        set_pl_rand(GLB_W);
        frame(8'h40, 1'b0, -1, "b2b_b");
        chk("b2b_pulses", 64'(ld_seen - ld0), 64'd2);

        for (int t = 0; t < 18; t++) begin
            hdr = 8'($urandom);
            if (hdr[7]) hdr[5:0] = 6'($urandom_range(0, NCOL - 1));
            L = hdr[7] ? COLW : GLB_W;
            sel = $urandom_range(0, 5);
            set_pl_rand(sel == 0 ? L - 1 : (sel == 1 ? L + 1 : L));
            frame(hdr, 1'($urandom_range(0, 3) == 0), -1, "rand");
        end
        end_checks("final");

        chk("commit_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("readback_queue_drained", 64'(rb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
